// File: rtl/audio_net_pkg.sv
// Shared constants and types for the AudioNet serial framer.
// The saturating increment serves the optional underrun counter.
package audio_net_pkg;

  localparam int FRAME_W_DEF = 256;
  localparam int UNDERRUN_W  = 16;

  typedef enum logic [1:0] {IDLE, SYNC, RUN} ser_state_t;

  function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] v);
    return (&v) ? v : v + {{(UNDERRUN_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/frame_hold_buf.sv
// One-entry frame holding register: accepts when empty, empties on pop.
// in_ready is simply !out_valid, so it rises the cycle after a pop.
module frame_hold_buf
  import audio_net_pkg::*;
#(
  parameter int W = FRAME_W_DEF
) (
  input  logic         sclk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         pop
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = !valid_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/frame_serializer.sv
// MSB-first frame serializer with SYNC lock pulse and idle-frame fill on underrun.
// Underrun counter present only when FRAME_SER_UNDERRUN_CNT_EN is defined.
module frame_serializer
  import audio_net_pkg::*;
#(
  parameter int                 FRAME_W      = FRAME_W_DEF,
  parameter logic [FRAME_W-1:0] IDLE_PATTERN = '0
) (
  input  logic                  sclk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FRAME_W-1:0]    in_data,
  output logic                  sdata,
  output logic                  sfs,
  output logic                  busy,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);

  localparam int                CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0]  LAST_M1 = CNT_W'(FRAME_W - 2);

  logic               hold_valid;
  logic [FRAME_W-1:0] hold_data;
  logic               pop;
  logic               boundary;
  logic [FRAME_W-1:0] next_frame;

  ser_state_t         state_q;
  logic [FRAME_W-1:0] shift_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sdata_q;
  logic               sfs_q;

  frame_hold_buf #(.W(FRAME_W)) u_hold (
    .sclk      (sclk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (hold_valid),
    .out_data  (hold_data),
    .pop       (pop)
  );

  assign boundary   = (state_q == RUN) && (cnt_q == LAST);
  assign pop        = hold_valid && ((state_q == IDLE) || boundary);
  assign next_frame = hold_valid ? hold_data : IDLE_PATTERN;

  // sdata_q/sfs_q always show the bit for the current cnt_q; the shifter holds the rest.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      sdata_q <= 1'b0;
      sfs_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sdata_q <= 1'b0;
          sfs_q   <= 1'b0;
          if (hold_valid) begin
            state_q <= SYNC;
            shift_q <= hold_data;
            sfs_q   <= 1'b1;
          end
        end
        SYNC: begin
          state_q <= RUN;
          cnt_q   <= '0;
          sdata_q <= shift_q[FRAME_W-1];
          shift_q <= {shift_q[FRAME_W-2:0], 1'b0};
          sfs_q   <= 1'b0;
        end
        RUN: begin
          if (boundary) begin
            cnt_q   <= '0;
            sdata_q <= next_frame[FRAME_W-1];
            shift_q <= {next_frame[FRAME_W-2:0], 1'b0};
            sfs_q   <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            sdata_q <= shift_q[FRAME_W-1];
            shift_q <= {shift_q[FRAME_W-2:0], 1'b0};
            sfs_q   <= (cnt_q == LAST_M1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sdata = sdata_q;
  assign sfs   = sfs_q;
  assign busy  = (state_q != IDLE);

`ifdef FRAME_SER_UNDERRUN_CNT_EN
  logic [UNDERRUN_W-1:0] underrun_q;

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      underrun_q <= '0;
    end else if (boundary && !hold_valid) begin
      underrun_q <= sat_inc(underrun_q);
    end
  end

  assign underrun_cnt = underrun_q;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer with a small deserializer model on the serial side.
module tb_frame_serializer;
  import audio_net_pkg::*;

  localparam int W = 256;
`ifdef FRAME_SER_UNDERRUN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         sclk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         sdata;
  logic         sfs;
  logic         busy;
  logic [15:0]  underrun_cnt;

  int checks = 0;
  int failures = 0;

  always #5 sclk = ~sclk;

  frame_serializer #(.FRAME_W(W)) dut (
    .sclk         (sclk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .sdata        (sdata),
    .sfs          (sfs),
    .busy         (busy),
    .underrun_cnt (underrun_cnt)
  );

  // Receiver model: locks on the first sfs, then collects each frame ending at sfs.
  logic [W-1:0] rx_sh = '0;
  int           rx_bits = 0;
  bit           rx_locked = 1'b0;
  logic [W-1:0] rx_q[$];
  int           rx_len_q[$];

  always @(negedge sclk or negedge rstn) begin
    if (!rstn) begin
      rx_locked = 1'b0;
      rx_bits   = 0;
    end else if (rx_locked) begin
      rx_sh   = {rx_sh[W-2:0], sdata};
      rx_bits = rx_bits + 1;
      if (sfs) begin
        rx_q.push_back(rx_sh);
        rx_len_q.push_back(rx_bits);
        rx_bits = 0;
      end
    end else if (sfs) begin
      rx_locked = 1'b1;
      rx_bits   = 0;
    end
  end

  typedef struct {
    logic [W-1:0] din;
    int           exp_wait;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge sclk);
    #1;
  endtask

  task automatic wait_frames(input int n, input int lim);
    int guard;
    guard = 0;
    while (rx_q.size() < n && guard < lim) begin
      step();
      guard++;
    end
    chk("frame_wait_timeout", W'(rx_q.size() >= n), W'(1));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    in_valid = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    step();
    rx_q.delete();
    rx_len_q.delete();
  endtask

  logic [W-1:0] f1;
  logic [W-1:0] fx;
  logic [W-1:0] f5;
  int           ones;
  int           sfsn;
  int           waited;

  initial begin
    f1 = '0;
    f1[W-1] = 1'b1;
    f1[0] = 1'b1;
    fx = {64'hDEAD_BEEF_0BAD_F00D, {(W-64){1'b0}}};
    f5 = {{(W/2){1'b1}}, {(W/2){1'b0}}} ^ {{(W-16){1'b0}}, 16'h5A5A};
    for (int i = 0; i < 4; i++) begin
      vecs[i].din = {32'hC0DE_0000 + 32'(i), {(W-64){1'b0}}, 32'(i + 1)};
    end
    vecs[0].exp_wait = 0;
    vecs[1].exp_wait = 1;
    vecs[2].exp_wait = 256;
    vecs[3].exp_wait = 255;

    // Reset values
    repeat (3) step();
    chk("rst_sdata", W'(sdata), W'(0));
    chk("rst_sfs", W'(sfs), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_underrun", W'(underrun_cnt), W'(0));
    rstn = 1'b1;
    step();

    // Single frame 8000...0001 with exact bit timing, followed by idle fill
    in_valid = 1'b1;
    in_data  = f1;
    step();
    in_valid = 1'b0;
    chk("accept_ready_low", W'(in_ready), W'(0));
    chk("pre_sync_sfs", W'(sfs), W'(0));
    step();
    chk("sync_sfs", W'(sfs), W'(1));
    chk("sync_sdata", W'(sdata), W'(0));
    chk("sync_busy", W'(busy), W'(1));
    chk("sync_ready_back", W'(in_ready), W'(1));
    step();
    chk("first_bit", W'(sdata), W'(1));
    chk("first_sfs", W'(sfs), W'(0));
    ones = 0;
    sfsn = 0;
    repeat (254) begin
      step();
      ones += int'(sdata);
      sfsn += int'(sfs);
    end
    chk("mid_ones", W'(ones), W'(0));
    chk("mid_sfs", W'(sfsn), W'(0));
    step();
    chk("last_bit", W'(sdata), W'(1));
    chk("last_sfs", W'(sfs), W'(1));
    wait_frames(1, 10);
    chk("rx_f1", rx_q[0], f1);
    chk("rx_f1_len", W'(rx_len_q[0]), W'(256));
    step();
    chk("underrun_1", W'(underrun_cnt), CNT_EN ? W'(1) : W'(0));
    chk("idle_sdata", W'(sdata), W'(0));
    chk("idle_busy", W'(busy), W'(1));
    wait_frames(3, 1000);
    step();
    chk("underrun_3", W'(underrun_cnt), CNT_EN ? W'(3) : W'(0));
    chk("rx_idle1", rx_q[1], '0);
    chk("rx_idle2", rx_q[2], '0);
    chk("rx_idle_len", W'(rx_len_q[2]), W'(256));

`ifdef FRAME_SER_UNDERRUN_CNT_EN
    dut.underrun_q = 16'hFFFE;
    rx_q.delete();
    rx_len_q.delete();
    wait_frames(1, 400);
    step();
    chk("sat_first", W'(underrun_cnt), W'(16'hFFFF));
    wait_frames(3, 1000);
    step();
    chk("sat_hold", W'(underrun_cnt), W'(16'hFFFF));
`endif

    // Back-to-back frames with in_valid held high
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].din;
      waited   = 0;
      while (!in_ready && waited < 1000) begin
        step();
        waited++;
      end
      chk($sformatf("b2b_wait%0d", i), W'(waited), W'(vecs[i].exp_wait));
      step();
      chk($sformatf("b2b_ready_low%0d", i), W'(in_ready), W'(0));
    end
    in_valid = 1'b0;
    wait_frames(4, 2000);
    chk("b2b_underrun", W'(underrun_cnt), W'(0));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_frame%0d", i), rx_q[i], vecs[i].din);
      chk($sformatf("b2b_len%0d", i), W'(rx_len_q[i]), W'(256));
    end

    // Reset at cnt=100 with a frame waiting in the buffer
    do_reset();
    in_valid = 1'b1;
    in_data  = '1;
    step();
    in_valid = 1'b0;
    step();
    in_valid = 1'b1;
    in_data  = fx;
    step();
    in_valid = 1'b0;
    repeat (100) step();
    chk("mid_pre_sdata", W'(sdata), W'(1));
    chk("mid_pre_ready", W'(in_ready), W'(0));
    rstn = 1'b0;
    #1;
    chk("mid_rst_sdata", W'(sdata), W'(0));
    chk("mid_rst_sfs", W'(sfs), W'(0));
    chk("mid_rst_busy", W'(busy), W'(0));
    chk("mid_rst_ready", W'(in_ready), W'(1));
    repeat (2) step();
    rstn = 1'b1;
    step();
    rx_q.delete();
    rx_len_q.delete();
    repeat (3) step();
    chk("post_rst_idle", W'(busy), W'(0));
    in_valid = 1'b1;
    in_data  = f5;
    step();
    in_valid = 1'b0;
    step();
    chk("restart_sfs", W'(sfs), W'(1));
    chk("restart_sdata", W'(sdata), W'(0));
    wait_frames(1, 600);
    chk("restart_frame", rx_q[0], f5);
    chk("restart_len", W'(rx_len_q[0]), W'(256));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
